// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant and bounded hold time.
// A requester keeps the grant for up to MAX_HOLD cycles while others wait.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Candidates exclude the current owner so a forced rotation always moves on.
  logic [3:0] cand;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] pick_idx;
  logic       found;
  logic       owner_req;

  assign cand      = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

  // rot[k] is the candidate k positions after ptr, so bit 0 has highest priority.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot[gi] = cand[ptr_q + 2'(gi)];
  end

  always_comb begin
    off   = 2'd0;
    found = |rot;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    pick_idx = ptr_q + off;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d     = ST_GRANT;
          gnt_d       = 4'b0001 << pick_idx;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = pick_idx + 2'd1;
          hold_cnt_d  = 8'd0;
        end
      end
      default: begin
        if (owner_req && (hold_cnt_q < HOLD_LAST)) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else if (found) begin
          gnt_d       = 4'b0001 << pick_idx;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = pick_idx + 2'd1;
          hold_cnt_d  = 8'd0;
        end else if (owner_req) begin
          // Sole requester at its limit: keep it, restart the hold window.
          hold_cnt_d = 8'd0;
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: hand-computed grant sequences plus a
// per-cycle one-hot / index consistency monitor.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int checks_cnt;
  int errors_cnt;

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v,
                     input bit quiet = 1'b0);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end else if (!quiet) begin
      $display("ok   %s: %0h (t=%0t)", tag, obs, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic v);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(v));
  endtask

  // Independent encoding of the grant, used by the per-cycle monitor.
  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("mon.onehot0", 32'($onehot0(gnt)), 32'd1, 1'b1);
    chk("mon.idx",     32'(gnt_idx), 32'(enc(gnt)), 1'b1);
    chk("mon.vld",     32'(gnt_valid), 32'(|gnt), 1'b1);
  end

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    chk_out("reset", 4'b0000, 2'd0, 1'b0);

    // First edge after release arbitrates normally.
    rst_n = 1'b1;
    req   = 4'b0001;
    step();
    chk_out("first_req0", 4'b0001, 2'd0, 1'b1);

    // Owner drops, grant passes directly to 2 (ptr becomes 3).
    req = 4'b0100;
    step();
    chk_out("handoff_2", 4'b0100, 2'd2, 1'b1);

    // From ptr=3 order is 3,0,1,2: requester 0 wins over 1.
    req = 4'b0011;
    step();
    chk_out("wrap_0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0010;
    step();
    chk_out("handoff_1", 4'b0010, 2'd1, 1'b1);

    req = 4'b0000;
    step();
    chk_out("to_idle", 4'b0000, 2'd0, 1'b0);

    // Sole requester held 20 cycles: hold window wraps, grant never drops.
    req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("solo1[%0d].gnt", k), 32'(gnt), 32'h2);
      chk($sformatf("solo1[%0d].vld", k), 32'(gnt_valid), 32'h1, 1'b1);
    end
    req = 4'b0000;
    step();
    chk_out("solo_idle", 4'b0000, 2'd0, 1'b0);

    // Reset to restart at ptr=0, then all four requesting: 8 cycles each.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 33; k++) begin
      logic [3:0] eg;
      int         ei;
      ei = (k / 8) % 4;
      eg = 4'b0001 << ei;
      step();
      chk($sformatf("rot[%0d].gnt", k), 32'(gnt), 32'(eg));
      chk($sformatf("rot[%0d].idx", k), 32'(gnt_idx), 32'(ei), 1'b1);
    end

    // Asynchronous reset mid-grant drops the grant without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
    req = 4'b1000;
    #2 rst_n = 1'b1;
    step();
    chk_out("post_rst_3", 4'b1000, 2'd3, 1'b1);

    req = 4'b0000;
    step();
    chk_out("final_idle", 4'b0000, 2'd0, 1'b0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
